// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - FSM state encoding and redirect-alignment masks for pc_fetch_gen
package pc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_TRAP = 2'd2
  } pc_state_t;

  localparam logic [1:0] ALIGN_MASK_32 = 2'b11;
  localparam logic [1:0] ALIGN_MASK_16 = 2'b01;

  function automatic logic [1:0] align_mask(input int ialign);
    return (ialign == 16) ? ALIGN_MASK_16 : ALIGN_MASK_32;
  endfunction

endpackage

// File: rtl/pc_fetch_gen_if.sv
// rtl/pc_fetch_gen_if.sv - valid/ready fetch request bus toward instruction memory
interface pc_fetch_gen_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] o_pc;
  logic            o_fetch_valid;
  logic            i_fetch_ready;
  logic            o_fetch_kill;

  modport master (output o_pc, output o_fetch_valid, input i_fetch_ready, output o_fetch_kill);
  modport slave  (input o_pc, input o_fetch_valid, output i_fetch_ready, input o_fetch_kill);
endinterface

// File: rtl/pc_ras.sv
// rtl/pc_ras.sv - circular return-address stack; push on full overwrites the oldest entry
module pc_ras #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            push,
  input  logic [XLEN-1:0] push_addr,
  input  logic            pop,
  output logic [XLEN-1:0] top,
  output logic            empty,
  output logic            full
);
  localparam int PW = $clog2(DEPTH);

  logic [XLEN-1:0] mem [DEPTH];
  logic [PW-1:0]   ptr;
  logic [PW:0]     count;
  logic [PW-1:0]   top_idx;

  assign top_idx = ptr - PW'(1);
  assign top     = mem[top_idx];
  assign empty   = (count == '0);
  assign full    = (count == (PW+1)'(DEPTH));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ptr   <= '0;
      count <= '0;
    end else if (push && pop && !empty) begin
      ptr   <= ptr;
    end else if (push) begin
      ptr <= ptr + PW'(1);
      if (!full) count <= count + (PW+1)'(1);
    end else if (pop && !empty) begin
      ptr   <= top_idx;
      count <= count - (PW+1)'(1);
    end
  end

  // Simultaneous push/pop replaces the top in place so depth is unchanged.
  always_ff @(posedge i_clk) begin
    if (push && pop && !empty) mem[top_idx] <= push_addr;
    else if (push)             mem[ptr]     <= push_addr;
  end
endmodule

// File: rtl/pc_fetch_gen.sv
// rtl/pc_fetch_gen.sv - PC generator with fetch handshake, trap on misaligned redirect; optional RAS under PC_RAS_EN
module pc_fetch_gen
  import pc_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'('h400),
  parameter int              IALIGN    = 32,
  parameter int              INC_BYTES = 4,
  parameter int              RAS_DEPTH = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load_start,
  input  logic [XLEN-1:0]   i_start_addr,
  input  logic              i_go,
  input  logic              i_stall,
  input  logic              i_redirect,
  input  logic [XLEN-1:0]   i_redirect_addr,
  input  logic              i_ras_push,
  input  logic [XLEN-1:0]   i_ras_push_addr,
  input  logic              i_ras_pop,
  pc_fetch_gen_if.master    fetch,
  output logic              o_misaligned,
  output logic [XLEN-1:0]   o_bad_addr,
  output logic              o_ras_empty,
  output logic [1:0]        o_state
);
  localparam logic [1:0] MASK = align_mask(IALIGN);

  pc_state_t       state, state_n;
  logic [XLEN-1:0] pc, pc_n, bad_n;
  logic            kill_n, mis_n, valid, misalign;
  logic            ras_push, ras_pop, ras_empty;
  logic [XLEN-1:0] ras_top;

`ifdef PC_RAS_EN
  logic ras_unused_full;
  pc_ras #(.XLEN(XLEN), .DEPTH(RAS_DEPTH)) u_ras (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .push      (ras_push),
    .push_addr (i_ras_push_addr),
    .pop       (ras_pop),
    .top       (ras_top),
    .empty     (ras_empty),
    .full      (ras_unused_full)
  );
`else
  logic unused_ras_inputs;
  assign unused_ras_inputs = &{1'b0, i_ras_push, i_ras_pop, i_ras_push_addr, ras_push, ras_pop};
  assign ras_empty = 1'b1;
  assign ras_top   = '0;
`endif

  assign valid    = (state == ST_RUN) && !i_stall;
  assign misalign = |(i_redirect_addr[1:0] & MASK);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state              <= ST_IDLE;
      pc                 <= RESET_VEC;
      fetch.o_fetch_kill <= 1'b0;
      o_misaligned       <= 1'b0;
      o_bad_addr         <= '0;
    end else begin
      state              <= state_n;
      pc                 <= pc_n;
      fetch.o_fetch_kill <= kill_n;
      o_misaligned       <= mis_n;
      o_bad_addr         <= bad_n;
    end
  end

  always_comb begin
    state_n  = state;
    pc_n     = pc;
    bad_n    = o_bad_addr;
    kill_n   = 1'b0;
    mis_n    = 1'b0;
    ras_push = 1'b0;
    ras_pop  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_load_start) pc_n = i_start_addr;
        if (i_go)         state_n = ST_RUN;
      end
      ST_RUN: begin
        ras_push = i_ras_push;
        if (i_redirect) begin
          kill_n = valid && !fetch.i_fetch_ready;
          if (misalign) begin
            mis_n   = 1'b1;
            bad_n   = i_redirect_addr;
            state_n = ST_TRAP;
          end else begin
            pc_n = i_redirect_addr;
          end
        end else if (i_ras_pop && !ras_empty) begin
          ras_pop = 1'b1;
          pc_n    = ras_top;
          kill_n  = valid && !fetch.i_fetch_ready;
        end else if (valid && fetch.i_fetch_ready) begin
          pc_n = pc + XLEN'(INC_BYTES);
        end
      end
      ST_TRAP: begin
        pc_n    = TRAP_VEC;
        state_n = ST_RUN;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign fetch.o_pc          = pc;
  assign fetch.o_fetch_valid = valid;
  assign o_ras_empty         = ras_empty;
  assign o_state             = state;
endmodule

// File: tb/tb_pc_fetch_gen.sv
// tb/tb_pc_fetch_gen.sv - directed self-checking bench for pc_fetch_gen (IALIGN 32 and 16 instances)
module tb_pc_fetch_gen;
  logic        clk = 1'b0;
  logic        rst, load_start, go, stall, redirect, ras_push, ras_pop, ready;
  logic [31:0] start_addr, redirect_addr, ras_push_addr;
  logic        mis32, mis16, empty32, empty16;
  logic [31:0] bad32, bad16;
  logic [1:0]  st32, st16;
  int          compared = 0;
  int          mismatched = 0;

  always #5 clk = ~clk;

  pc_fetch_gen_if #(.XLEN(32)) if32 ();
  pc_fetch_gen_if #(.XLEN(32)) if16 ();
  assign if32.i_fetch_ready = ready;
  assign if16.i_fetch_ready = ready;

  pc_fetch_gen #(.IALIGN(32)) dut32 (
    .i_clk(clk), .i_rst(rst), .i_load_start(load_start), .i_start_addr(start_addr),
    .i_go(go), .i_stall(stall), .i_redirect(redirect), .i_redirect_addr(redirect_addr),
    .i_ras_push(ras_push), .i_ras_push_addr(ras_push_addr), .i_ras_pop(ras_pop),
    .fetch(if32), .o_misaligned(mis32), .o_bad_addr(bad32), .o_ras_empty(empty32), .o_state(st32)
  );

  pc_fetch_gen #(.IALIGN(16)) dut16 (
    .i_clk(clk), .i_rst(rst), .i_load_start(load_start), .i_start_addr(start_addr),
    .i_go(go), .i_stall(stall), .i_redirect(redirect), .i_redirect_addr(redirect_addr),
    .i_ras_push(ras_push), .i_ras_push_addr(ras_push_addr), .i_ras_pop(ras_pop),
    .fetch(if16), .o_misaligned(mis16), .o_bad_addr(bad16), .o_ras_empty(empty16), .o_state(st16)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1; load_start = 0; go = 0; stall = 0; redirect = 0; ras_push = 0; ras_pop = 0;
    ready = 0; start_addr = 0; redirect_addr = 0; ras_push_addr = 0;
    tick(); tick();
    compared++; if (if32.o_pc !== 32'h0) begin mismatched++; $display("FAIL reset_pc got %h exp 0", if32.o_pc); end
    compared++; if (st32 !== 2'd0) begin mismatched++; $display("FAIL reset_state got %0d exp 0", st32); end
    compared++; if (if32.o_fetch_valid !== 1'b0) begin mismatched++; $display("FAIL reset_valid got %b exp 0", if32.o_fetch_valid); end
    compared++; if (if32.o_fetch_kill !== 1'b0 || mis32 !== 1'b0) begin mismatched++; $display("FAIL reset_pulses got %b%b exp 00", if32.o_fetch_kill, mis32); end
    compared++; if (bad32 !== 32'h0) begin mismatched++; $display("FAIL reset_bad got %h exp 0", bad32); end
    compared++; if (empty32 !== 1'b1) begin mismatched++; $display("FAIL reset_ras_empty got %b exp 1", empty32); end
    rst = 0;
  endtask

  task automatic test_sequential();
    load_start = 1; start_addr = 32'h100; go = 1; ready = 1;
    tick();
    load_start = 0; go = 0;
    compared++; if (st32 !== 2'd1) begin mismatched++; $display("FAIL seq_state got %0d exp 1", st32); end
    for (int i = 0; i < 3; i++) begin
      compared++;
      if (if32.o_pc !== 32'h100 + 32'(4 * i) || if32.o_fetch_valid !== 1'b1) begin
        mismatched++; $display("FAIL seq_pc%0d got %h/%b exp %h/1", i, if32.o_pc, if32.o_fetch_valid, 32'h100 + 32'(4 * i));
      end
      tick();
    end
  endtask

  task automatic test_hold();
    redirect = 1; redirect_addr = 32'h200;
    tick();
    redirect = 0; ready = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      compared++;
      if (if32.o_pc !== 32'h200 || if32.o_fetch_valid !== 1'b1 || if32.o_fetch_kill !== 1'b0) begin
        mismatched++; $display("FAIL hold%0d got pc %h v %b k %b exp 200/1/0", i, if32.o_pc, if32.o_fetch_valid, if32.o_fetch_kill);
      end
    end
    stall = 1; ready = 1;
    #1;
    compared++; if (if32.o_fetch_valid !== 1'b0) begin mismatched++; $display("FAIL stall_valid got %b exp 0", if32.o_fetch_valid); end
    tick();
    compared++; if (if32.o_pc !== 32'h200) begin mismatched++; $display("FAIL stall_pc got %h exp 200", if32.o_pc); end
    stall = 0; ready = 0;
  endtask

  task automatic test_kill();
    redirect = 1; redirect_addr = 32'h3000;
    tick();
    redirect = 0;
    compared++; if (if32.o_fetch_kill !== 1'b1 || if32.o_pc !== 32'h3000) begin
      mismatched++; $display("FAIL kill_pulse got k %b pc %h exp 1/3000", if32.o_fetch_kill, if32.o_pc); end
    tick();
    compared++; if (if32.o_fetch_kill !== 1'b0 || if32.o_pc !== 32'h3000) begin
      mismatched++; $display("FAIL kill_end got k %b pc %h exp 0/3000", if32.o_fetch_kill, if32.o_pc); end
  endtask

  task automatic test_misaligned();
    ready = 1; redirect = 1; redirect_addr = 32'h1002;
    tick();
    redirect = 0;
    compared++; if (mis32 !== 1'b1 || bad32 !== 32'h1002 || st32 !== 2'd2 || if32.o_fetch_valid !== 1'b0) begin
      mismatched++; $display("FAIL mis_trap got m %b bad %h st %0d v %b exp 1/1002/2/0", mis32, bad32, st32, if32.o_fetch_valid); end
    compared++; if (if32.o_fetch_kill !== 1'b0) begin mismatched++; $display("FAIL mis_kill got %b exp 0", if32.o_fetch_kill); end
    compared++; if (mis16 !== 1'b0 || if16.o_pc !== 32'h1002) begin
      mismatched++; $display("FAIL ialign16 got m %b pc %h exp 0/1002", mis16, if16.o_pc); end
    tick();
    compared++; if (if32.o_pc !== 32'h400 || st32 !== 2'd1 || mis32 !== 1'b0 || bad32 !== 32'h1002) begin
      mismatched++; $display("FAIL trap_vec got pc %h st %0d m %b bad %h exp 400/1/0/1002", if32.o_pc, st32, mis32, bad32); end
  endtask

  task automatic test_wrap_and_reset();
    redirect = 1; redirect_addr = 32'hFFFF_FFFC;
    tick();
    redirect = 0;
    compared++; if (if32.o_pc !== 32'hFFFF_FFFC) begin mismatched++; $display("FAIL wrap_pre got %h exp fffffffc", if32.o_pc); end
    tick();
    compared++; if (if32.o_pc !== 32'h0 || mis32 !== 1'b0) begin mismatched++; $display("FAIL wrap got pc %h m %b exp 0/0", if32.o_pc, mis32); end
    stall = 1;
    tick();
    ready = 0; stall = 0;
    tick();
    rst = 1;
    tick();
    rst = 0;
    compared++; if (if32.o_pc !== 32'h0 || st32 !== 2'd0 || if32.o_fetch_valid !== 1'b0 || if32.o_fetch_kill !== 1'b0) begin
      mismatched++; $display("FAIL mid_reset got pc %h st %0d v %b k %b exp 0/0/0/0", if32.o_pc, st32, if32.o_fetch_valid, if32.o_fetch_kill); end
  endtask

  task automatic test_idle_ignore();
    redirect = 1; redirect_addr = 32'h500; ready = 1;
    tick();
    redirect = 0;
    compared++; if (if32.o_pc !== 32'h0 || st32 !== 2'd0) begin mismatched++; $display("FAIL idle_ignore got pc %h st %0d exp 0/0", if32.o_pc, st32); end
    go = 1;
    tick();
    go = 0;
  endtask

`ifdef PC_RAS_EN
  task automatic test_ras();
    logic [31:0] exp_pc;
    ras_push = 1; ras_push_addr = 32'hA0; tick();
    ras_push_addr = 32'hB0; tick();
    ras_push = 0;
    compared++; if (empty32 !== 1'b0) begin mismatched++; $display("FAIL ras_nonempty got %b exp 0", empty32); end
    ras_pop = 1; tick();
    compared++; if (if32.o_pc !== 32'hB0) begin mismatched++; $display("FAIL ras_pop1 got %h exp b0", if32.o_pc); end
    tick();
    compared++; if (if32.o_pc !== 32'hA0) begin mismatched++; $display("FAIL ras_pop2 got %h exp a0", if32.o_pc); end
    tick();
    compared++; if (if32.o_pc !== 32'hA4 || empty32 !== 1'b1) begin mismatched++; $display("FAIL ras_pop_empty got %h e %b exp a4/1", if32.o_pc, empty32); end
    ras_pop = 0; ras_push = 1;
    for (int i = 1; i <= 5; i++) begin ras_push_addr = 32'(i * 16); tick(); end
    ras_push = 0; ras_pop = 1;
    for (int i = 5; i >= 2; i--) begin
      tick();
      exp_pc = 32'(i * 16);
      compared++; if (if32.o_pc !== exp_pc) begin mismatched++; $display("FAIL ras_ovf_pop%0d got %h exp %h", i, if32.o_pc, exp_pc); end
    end
    ras_pop = 0;
    compared++; if (empty32 !== 1'b1) begin mismatched++; $display("FAIL ras_ovf_empty got %b exp 1", empty32); end
  endtask
`else
  task automatic test_ras();
    logic [31:0] base;
    base = if32.o_pc;
    ras_push = 1; ras_push_addr = 32'hA0; tick();
    ras_push = 0; ras_pop = 1; tick();
    ras_pop = 0;
    compared++; if (if32.o_pc !== base + 32'd8 || empty32 !== 1'b1) begin
      mismatched++; $display("FAIL ras_disabled got %h e %b exp %h/1", if32.o_pc, empty32, base + 32'd8); end
  endtask
`endif

  initial begin
    test_reset();
    test_sequential();
    test_hold();
    test_kill();
    test_misaligned();
    test_wrap_and_reset();
    test_idle_ignore();
    test_ras();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
